// File: rtl/hdmi_timing_engine.sv
// Programmable HDMI timing engine: sync/DE generation, frame and text RAM addressing with
// flip/invert, and an output pipeline that realigns control signals with RAM read data.
module hdmi_timing_engine #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   PX_W       = 8,
  parameter int   ADDR_W     = 19,
  parameter int   TXT_ADDR_W = 14,
  parameter int   RD_LAT     = 1,
  parameter int   OVL_X0     = 2,
  parameter int   OVL_Y0     = 452,
  parameter int   OVL_W      = 100,
  parameter int   OVL_H      = 26
) (
  input  logic                  CLK_PX,
  input  logic                  RST_n,
  input  logic                  READY,
  input  logic [2:0]            MODE,
  input  logic                  OVL_EN,
  input  logic [TXT_ADDR_W-1:0] TXT_BASE,
  input  logic [3*PX_W-1:0]     PX_IN,
  input  logic [PX_W-1:0]       TXT_IN,
  output logic [ADDR_W-1:0]     PX_ADDR,
  output logic [TXT_ADDR_W-1:0] TXT_ADDR,
  output logic                  HDMI_CLK,
  output logic                  DE,
  output logic                  HSYNC,
  output logic                  VSYNC,
  output logic [3*PX_W-1:0]     HDMI_PX
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int DL      = RD_LAT + 1;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'((V_ACTIVE - 1) * H_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP   = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(H_ACTIVE - 1);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic ovl;
    logic inv;
  } tag_t;

  logic [HC_W-1:0]       h_cnt;
  logic [VC_W-1:0]       v_cnt;
  logic [ADDR_W-1:0]     row_fwd;
  logic [2:0]            mode_s;
  logic                  ovl_en_s;
  logic [TXT_ADDR_W-1:0] txt_ptr;
  tag_t                  dl [DL];

  logic              h_last, v_last, frame_wrap, active, hs_on, vs_on, in_win;
  logic [ADDR_W-1:0] x_fwd, xc, row_base, pix_addr;
  tag_t              tail;

  assign HDMI_CLK   = CLK_PX;
  assign h_last     = (h_cnt == HC_W'(H_TOTAL - 1));
  assign v_last     = (v_cnt == VC_W'(V_TOTAL - 1));
  assign frame_wrap = h_last && v_last;
  assign active     = (h_cnt < HC_W'(H_ACTIVE)) && (v_cnt < VC_W'(V_ACTIVE));
  assign hs_on      = (h_cnt >= HC_W'(H_ACTIVE + H_FP)) && (h_cnt < HC_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on      = (v_cnt >= VC_W'(V_ACTIVE + V_FP)) && (v_cnt < VC_W'(V_ACTIVE + V_FP + V_SYNC));
  assign in_win     = ovl_en_s && active &&
                      (h_cnt >= HC_W'(OVL_X0)) && (h_cnt < HC_W'(OVL_X0 + OVL_W)) &&
                      (v_cnt >= VC_W'(OVL_Y0)) && (v_cnt < VC_W'(OVL_Y0 + OVL_H));

  // row_fwd only ever counts upward; the flipped base is derived by subtraction, no multiplier
  assign x_fwd    = ADDR_W'(h_cnt);
  assign xc       = mode_s[1] ? (X_LAST - x_fwd) : x_fwd;
  assign row_base = mode_s[2] ? (LAST_ROW - row_fwd) : row_fwd;
  assign pix_addr = row_base + xc;
  assign tail     = dl[DL-1];

  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      row_fwd  <= '0;
      mode_s   <= '0;
      ovl_en_s <= 1'b0;
      txt_ptr  <= '0;
      PX_ADDR  <= '0;
      TXT_ADDR <= '0;
    end else if (!READY) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      row_fwd  <= '0;
      mode_s   <= MODE;
      ovl_en_s <= OVL_EN;
      txt_ptr  <= TXT_BASE;
      TXT_ADDR <= TXT_BASE;
    end else begin
      if (active) PX_ADDR <= pix_addr;
      // Frame wrap falls in blanking, so it never competes with a window pixel
      if (frame_wrap) begin
        mode_s   <= MODE;
        ovl_en_s <= OVL_EN;
        txt_ptr  <= TXT_BASE;
        TXT_ADDR <= TXT_BASE;
      end else if (in_win) begin
        TXT_ADDR <= txt_ptr;
        txt_ptr  <= txt_ptr + 1'b1;
      end
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt   <= '0;
          row_fwd <= '0;
        end else begin
          v_cnt <= v_cnt + 1'b1;
          if (v_cnt < VC_W'(V_ACTIVE)) row_fwd <= row_fwd + H_STEP;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Tags ride RD_LAT+1 stages, then the output register makes RD_LAT+2 to match HDMI_PX
  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < DL; i++) dl[i] <= '0;
      DE      <= 1'b0;
      HSYNC   <= ~HS_POL;
      VSYNC   <= ~VS_POL;
      HDMI_PX <= '0;
    end else if (!READY) begin
      for (int i = 0; i < DL; i++) dl[i] <= '0;
      DE      <= 1'b0;
      HSYNC   <= ~HS_POL;
      VSYNC   <= ~VS_POL;
      HDMI_PX <= '0;
    end else begin
      dl[0] <= {active, hs_on, vs_on, in_win, mode_s[0]};
      for (int i = 1; i < DL; i++) dl[i] <= dl[i-1];
      DE    <= tail.de;
      HSYNC <= tail.hs ? HS_POL : ~HS_POL;
      VSYNC <= tail.vs ? VS_POL : ~VS_POL;
      if (!tail.de)      HDMI_PX <= '0;
      else if (tail.ovl) HDMI_PX <= {TXT_IN, TXT_IN, TXT_IN};
      else if (tail.inv) HDMI_PX <= ~PX_IN;
      else               HDMI_PX <= PX_IN;
    end
  end

endmodule

// File: doc/hdmi_timing_engine.md
Name: hdmi_timing_engine

Overview:
- Parametrised successor to the fixed 640x480 HDMI controller.
- Generates programmable video timing with configurable sync polarity.
- Issues frame-buffer and text-overlay read addresses and supports per-axis flip plus colour invert.
- Compensates a parametrised memory read latency so that pixel data, DE and syncs leave aligned. Sits between the frame/text RAMs and the HDMI transmitter.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch widths
- V_ACTIVE, 480, active lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync and back porch widths
- HS_POL / VS_POL, 0 / 0, asserted sync level
- PX_W, 8, bits per colour channel
- ADDR_W, 19, PX_ADDR width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- TXT_ADDR_W, 14, TXT_ADDR width
- RD_LAT, 1, RAM read latency in cycles (1..4)
- OVL_X0 / OVL_Y0, 2 / 452, overlay window origin in active coordinates
- OVL_W / OVL_H, 100 / 26, overlay window size

Ports:
- CLK_PX  in  1  pixel clock
- RST_n  in  1  reset
- READY  in  1  sync-domain enable; low holds engine idle
- MODE  in  3  [0] invert, [1] flip_h, [2] flip_v
- OVL_EN  in  1  overlay enable
- TXT_BASE  in  TXT_ADDR_W  text RAM base address for overlay
- PX_IN  in  3*PX_W  frame RAM data {R,G,B}
- TXT_IN  in  PX_W  text RAM data (grey level)
- PX_ADDR  out  ADDR_W  frame RAM read address
- TXT_ADDR  out  TXT_ADDR_W  text RAM read address
- HDMI_CLK  out  1  equals CLK_PX
- DE  out  1  data enable
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- HDMI_PX  out  3*PX_W  output pixel {R,G,B}

Behaviour:
- Reset and clock: RST_n asynchronous, active-low; clock CLK_PX.
- Reset values:
  - counters, PX_ADDR, TXT_ADDR, HDMI_PX, DE = 0
  - HSYNC = ~HS_POL, VSYNC = ~VS_POL
  - shadow MODE/OVL_EN/TXT_BASE = 0
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL = sum of the four H params).
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
  - Order per axis: active, front porch, sync, back porch.
  - Active when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - Hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync is the same form on v_cnt, whole lines.
- Shadow registers: MODE, OVL_EN and TXT_BASE are latched into shadows only when the counters wrap (h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1) or while READY is low. Mid-frame changes take effect the next frame.
- Pipeline (stage 0 = counters):
  - Stage 1: PX_ADDR/TXT_ADDR are registered for the stage-0 position.
  - RAM data returns RD_LAT cycles later.
  - Stage RD_LAT+2: HDMI_PX is registered.
  - DE/HSYNC/VSYNC and overlay flags travel through a matching (RD_LAT+2)-deep delay line, so they are aligned with HDMI_PX.
- Address generation, incremental with no multiplier:
  - PX_ADDR = row_base + xc.
  - xc = x, or H_ACTIVE-1-x when flip_h.
  - row_base starts at 0 and adds H_ACTIVE per active line; when flip_v it starts at (V_ACTIVE-1)*H_ACTIVE and subtracts H_ACTIVE.
  - Outside the active area PX_ADDR holds its last value.
- Overlay:
  - The window is x in [OVL_X0, OVL_X0+OVL_W) and y in [OVL_Y0, OVL_Y0+OVL_H), applied only when shadow OVL_EN = 1.
  - TXT_ADDR = TXT_BASE + (y-OVL_Y0)*OVL_W + (x-OVL_X0), incremented per window pixel.
  - TXT_ADDR holds outside the window, reloads TXT_BASE at frame start, and wraps modulo 2^TXT_ADDR_W.
  - Window pixel output = {TXT_IN,TXT_IN,TXT_IN}; invert is not applied.
  - Flip does not affect the overlay.
- Pixel output:
  - Active, non-overlay: PX_IN, bitwise inverted when shadow invert = 1.
  - Not active: HDMI_PX = 0.
- READY low:
  - Counters and row_base are cleared synchronously and held.
  - All delay-line valid/sync bits are cleared on the same edge, so DE = 0, syncs inactive and HDMI_PX = 0 from the next edge.
  - On READY rising, the timing restarts at (0,0).
- Edge cases:
  - RST_n asserted mid-frame returns everything to reset values immediately.
  - Simultaneous frame wrap and MODE change: the new MODE is captured.

Test Plan:
Common setup: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, RD_LAT=1.
- Timing: release reset with READY=1 -> DE high 8 cycles per line on lines 0..3, first DE 3 edges after (0,0); HSYNC low 3 cycles, 2 cycles after DE falls; VSYNC low for 16 cycles on line 5.
- Addresses: MODE=000 -> PX_ADDR line0 = 0..7, line3 = 24..31; MODE=010 -> line0 = 7..0; MODE=100 -> line0 = 24..31; MODE=110 -> line0 = 31..24.
- Invert: MODE=001, PX_IN=0x102030 -> HDMI_PX=0xEFDFCF; PX_IN=0x102030 with MODE=000 -> HDMI_PX=0x102030.
- Overlay: OVL_X0=2, OVL_Y0=1, OVL_W=3, OVL_H=2, TXT_BASE=100, OVL_EN=1 -> TXT_ADDR 100..102 on line1 and 103..105 on line2; TXT_IN=0x55 -> HDMI_PX=0x555555 in the window. OVL_EN=0 -> PX_IN passes.
- Mode shadowing: set MODE=010 at line 2 -> addresses unchanged until the next frame, whose line0 = 7..0.
- READY drop: READY=0 at h_cnt=4 on line1 -> next edge DE=0, HSYNC/VSYNC high, HDMI_PX=0; READY=1 -> PX_ADDR restarts at 0, first DE 3 edges later.
